// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC Direct-Form-I biquad sections sharing one multiplier-
// accumulator. Accepts one sample per 6*NSEC+1 clocks over a valid/ready
// handshake. Coefficients are programmable at run time while the block is idle.
module iir_biquad_cascade #(
  parameter int NSEC = 5,
  parameter int DW   = 16,
  parameter int CW   = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_sat,
  input  logic                 coef_we,
  output logic                 coef_ready,
  input  logic [5:0]           coef_addr,
  input  logic signed [CW-1:0] coef_wdata
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + 3;
  localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;

  localparam logic [SW-1:0]        LAST_SEC = SW'(NSEC - 1);
  localparam logic signed [CW-1:0] UNITY    = CW'(1) <<< (CW - 2);
  localparam logic signed [AW-1:0] RND      = AW'(1) <<< (CW - 3);
  localparam logic signed [DW-1:0] DMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] SMAX     = AW'(DMAX);
  localparam logic signed [AW-1:0] SMIN     = AW'(DMIN);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [SW-1:0]       sec_q, sec_d;
  logic                accept, wb, wb_last;

  // Input of the section currently being computed (sample, then previous y).
  logic signed [DW-1:0] xin_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 sticky_q;

  logic                 out_valid_q, out_sat_q;
  logic signed [DW-1:0] out_data_q;

  logic signed [CW-1:0] coef_q [NSEC][5];
  logic signed [DW-1:0] x1_q [NSEC];
  logic signed [DW-1:0] x2_q [NSEC];
  logic signed [DW-1:0] y1_q [NSEC];
  logic signed [DW-1:0] y2_q [NSEC];

  // A write that arrives together with a sample is parked here so the sample
  // in flight keeps computing with the old coefficient set.
  logic                 pend_q;
  logic [5:0]           pend_addr_q;
  logic signed [CW-1:0] pend_data_q;

  logic                 idle, direct_wr, pend_set, commit, wr_en;
  logic [5:0]           wr_addr;
  logic signed [CW-1:0] wr_data;

  logic signed [DW-1:0] op;
  logic signed [CW-1:0] cf;
  logic signed [PW-1:0] op_ext, cf_ext, prod;
  logic signed [AW-1:0] term;
  logic [DW:0]          rs;
  logic signed [DW-1:0] y_wb;
  logic                 sat_wb;

  // Round half-up at the Q(CW-2) binary point, then clamp to the sample range.
  // Bit DW of the result flags that clamping happened.
  function automatic logic [DW:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + RND) >>> (CW - 2);
    if (r > SMAX)      round_sat = {1'b1, DMAX};
    else if (r < SMIN) round_sat = {1'b1, DMIN};
    else               round_sat = {1'b0, r[DW-1:0]};
  endfunction

  assign idle       = (state_q == S_IDLE);
  assign in_ready   = idle;
  assign coef_ready = idle;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;

  // Sequencer: IDLE -> (MAC x5 -> WB) per section; clear abandons a sample.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sec_d   = sec_q;
    accept  = 1'b0;
    wb      = 1'b0;
    wb_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_MAC;
          k_d     = 3'd0;
          sec_d   = '0;
        end
      end
      S_MAC: begin
        if (k_q == 3'd4) state_d = S_WB;
        else             k_d     = k_q + 3'd1;
      end
      S_WB: begin
        wb  = 1'b1;
        k_d = 3'd0;
        if (sec_q == LAST_SEC) begin
          wb_last = 1'b1;
          state_d = S_IDLE;
        end else begin
          sec_d   = sec_q + 1'b1;
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear && !idle) begin
      state_d = S_IDLE;
      wb      = 1'b0;
      wb_last = 1'b0;
    end
  end

  // Coefficient write steering: direct in idle, deferred when a sample starts.
  always_comb begin
    direct_wr = idle && coef_we && !accept;
    pend_set  = idle && coef_we && accept;
    commit    = pend_q && !idle && (state_d == S_IDLE);
    wr_en     = direct_wr || commit;
    wr_addr   = direct_wr ? coef_addr  : pend_addr_q;
    wr_data   = direct_wr ? coef_wdata : pend_data_q;
  end

  // MAC operand selection and one product per cycle; a-terms are subtracted.
  always_comb begin
    op = '0;
    case (k_q)
      3'd0:    op = xin_q;
      3'd1:    op = x1_q[sec_q];
      3'd2:    op = x2_q[sec_q];
      3'd3:    op = y1_q[sec_q];
      3'd4:    op = y2_q[sec_q];
      default: op = '0;
    endcase
    cf     = coef_q[sec_q][k_q];
    op_ext = PW'(op);
    cf_ext = PW'(cf);
    prod   = op_ext * cf_ext;
    term   = AW'(prod);
    if (k_q >= 3'd3) term = -term;
    acc_d  = (k_q == 3'd0) ? term : acc_q + term;
  end

  assign rs     = round_sat(acc_q);
  assign y_wb   = rs[DW-1:0];
  assign sat_wb = rs[DW];

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sec_q   <= sec_d;
    end
  end

  // Datapath registers: section input, accumulator and parked coefficient write.
  always_ff @(posedge clk) begin
    if (accept)  xin_q <= in_data;
    else if (wb) xin_q <= y_wb;
    if (state_q == S_MAC) acc_q <= acc_d;
    if (pend_set) begin
      pend_addr_q <= coef_addr;
      pend_data_q <= coef_wdata;
    end
  end

  // Per-sample saturation flag, output register and parked-write flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      if (accept)            sticky_q <= 1'b0;
      else if (wb && sat_wb) sticky_q <= 1'b1;
      out_valid_q <= wb_last;
      if (wb_last) begin
        out_data_q <= y_wb;
        out_sat_q  <= sticky_q | sat_wb;
      end
      if (pend_set)    pend_q <= 1'b1;
      else if (commit) pend_q <= 1'b0;
    end
  end

  // Section history: shifted at writeback, zeroed by clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSEC; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else if (clear) begin
      for (int s = 0; s < NSEC; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else if (wb) begin
      x2_q[sec_q] <= x1_q[sec_q];
      x1_q[sec_q] <= xin_q;
      y2_q[sec_q] <= y1_q[sec_q];
      y1_q[sec_q] <= y_wb;
    end
  end

  // Coefficient bank; resets to passthrough (b0 = 1.0). Out-of-range addresses
  // match no entry and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < 5; k++)
          coef_q[s][k] <= (k == 0) ? UNITY : '0;
    end else if (wr_en) begin
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < 5; k++)
          if (wr_addr == 6'(s * 5 + k)) coef_q[s][k] <= wr_data;
    end
  end

endmodule
